adder_acc: RTL and testbench

Streaming, parametrised adder/accumulator: sums x + y + cin per beat and either passes the sum out, loads it into an accumulator, or adds it to the accumulator. Produces a zero flag and an overflow flag. Two-stage registered pipeline with valid/ready handshakes on both sides. Sits between operand producers and result consumers wherever the plain registered adder needs backpressure, accumulation or saturation.

---
 rtl/adder_acc.sv | 79 +++++++
 tb/tb_adder_acc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_acc.sv
// adder_acc: two-stage valid/ready adder with pass, load and accumulate modes,
// plus registered zero, overflow and last flags.
module adder_acc #(
    parameter int WIDTH     = 8,
    parameter int SWIDTH    = WIDTH + 1,
    parameter int ACC_WIDTH = WIDTH + 4,
    parameter bit SAT       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 cin,
    input  logic [1:0]           mode,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] sm,
    output logic                 sm_zero,
    output logic                 sm_ovf,
    output logic                 out_last
);
    localparam logic [1:0] MODE_ACC  = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;

    logic                 s1_valid, s1_last, adv1, adv2, is_acc, is_load, ovf;
    logic [1:0]           s1_mode;
    logic [SWIDTH-1:0]    s1_s;
    logic [ACC_WIDTH-1:0] acc, s_ext, res, acc_next;
    logic [ACC_WIDTH:0]   t;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    always_comb begin
        s_ext    = ACC_WIDTH'(s1_s);
        is_acc   = s1_mode == MODE_ACC;
        is_load  = s1_mode == MODE_LOAD;
        t        = {1'b0, acc} + {1'b0, s_ext};
        ovf      = is_acc && t[ACC_WIDTH];
        res      = !is_acc ? s_ext : (ovf && SAT) ? '1 : t[ACC_WIDTH-1:0];
        acc_next = s1_last ? '0 : (is_acc || is_load) ? res : acc;
    end

    // acc only moves when a beat enters stage 2, so a stalled result is never re-added
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
            sm        <= '0;
            sm_zero   <= 1'b0;
            sm_ovf    <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_s    <= SWIDTH'(x) + SWIDTH'(y) + SWIDTH'(cin);
                    s1_mode <= mode;
                    s1_last <= in_last;
                end
            end
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    sm       <= res;
                    sm_zero  <= res == '0;
                    sm_ovf   <= ovf;
                    out_last <= s1_last;
                    acc      <= acc_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_acc.sv
// tb_adder_acc: wrapping and saturating instances share one stimulus stream;
// expected results are queued at acceptance and checked by a monitor on delivery.
module tb_adder_acc;
    localparam int AW = 12;
    localparam logic [1:0] ADD = 2'b00, ACC = 2'b01, LOAD = 2'b10;

    typedef struct packed {
        logic [AW-1:0] sm;
        logic          zero;
        logic          ovf;
        logic          last;
    } res_t;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [7:0] x = '0, y = '0;
    logic [1:0] mode = '0;
    logic ir0, ir1, ov0, ov1, z0, z1, f0, f1, l0, l1;
    logic [AW-1:0] sm0, sm1;
    res_t q0[$], q1[$];
    int nvec = 0, nerr = 0, n_acc = 0, rdy_mode = 0;
    int macc[2] = '{0, 0};

    adder_acc #(.WIDTH(8), .ACC_WIDTH(AW), .SAT(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .x(x), .y(y), .cin(cin),
        .mode(mode), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .sm(sm0),
        .sm_zero(z0), .sm_ovf(f0), .out_last(l0));
    adder_acc #(.WIDTH(8), .ACC_WIDTH(AW), .SAT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .x(x), .y(y), .cin(cin),
        .mode(mode), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .sm(sm1),
        .sm_zero(z1), .sm_ovf(f1), .out_last(l1));

    always #5 clk = ~clk;

    // ready pattern: 0 always ready, 1 held low, 2 random
    initial forever begin
        @(negedge clk);
        out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(input int i, input res_t act);
        res_t e;
        nvec++;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            nerr++;
            $display("FAIL out%0d unexpected beat: sm=%0d", i, act.sm);
            return;
        end
        if (i == 0) e = q0.pop_front();
        else e = q1.pop_front();
        if (act !== e) begin
            nerr++;
            $display("FAIL out%0d beat: got sm=%0d z=%b o=%b l=%b expected sm=%0d z=%b o=%b l=%b",
                     i, act.sm, act.zero, act.ovf, act.last, e.sm, e.zero, e.ovf, e.last);
        end
    endtask

    initial forever begin
        @(negedge clk);
        #4;
        if (rst_n && out_ready) begin
            if (ov0) cmp(0, {sm0, z0, f0, l0});
            if (ov1) cmp(1, {sm1, z1, f1, l1});
        end
    end

    // Called just after a negedge; returns at the negedge following acceptance with in_valid still high.
    task automatic beat(input logic [7:0] bx, input logic [7:0] by, input logic bc, input logic [1:0] bm,
                        input logic bl, input bit use_exp, input int e0, input int e1, input logic eovf);
        int s, t, r;
        bit o, ok;
        res_t e;
        x = bx; y = by; cin = bc; mode = bm; in_last = bl; in_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            #4;
            ok = ir0;
            @(negedge clk);
        end
        if (!ok) begin
            nvec++; nerr++;
            $display("FAIL accept timeout: in_ready=%b expected 1", ir0);
            return;
        end
        n_acc++;
        s = int'(bx) + int'(by) + int'(bc);
        for (int i = 0; i < 2; i++) begin
            o = 0;
            r = s;
            if (bm == ACC) begin
                t = macc[i] + s;
                o = t > 4095;
                r = !o ? t : (i == 1 ? 4095 : t - 4096);
                macc[i] = r;
            end else if (bm == LOAD) macc[i] = s;
            if (bl) macc[i] = 0;
            e.sm   = AW'(use_exp ? (i == 0 ? e0 : e1) : r);
            e.ovf  = use_exp ? eovf : o;
            e.zero = e.sm == 0;
            e.last = bl;
            if (i == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 300 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            nvec++; nerr++;
            $display("FAIL drain timeout: pending=%0d expected 0", q0.size() + q1.size());
            q0.delete(); q1.delete();
        end
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #4;
        chk("rst in_ready", ir0, 1);
        chk("rst out_valid", ov0, 0);
        chk("rst sm", sm0, 0);
        chk("rst sm_zero", z0, 0);
        chk("rst sm_ovf", f0, 0);
        chk("rst out_last", l0, 0);
        chk("rst out_valid sat", ov1, 0);
        @(negedge clk);

        beat(8'd255, 8'd255, 1'b1, ADD, 1'b0, 1, 511, 511, 1'b0);
        beat(8'd0, 8'd0, 1'b0, ADD, 1'b0, 1, 0, 0, 1'b0);
        beat(8'd3, 8'd4, 1'b0, 2'b11, 1'b0, 1, 7, 7, 1'b0);
        drain();

        beat(8'd255, 8'd255, 1'b1, LOAD, 1'b0, 1, 511, 511, 1'b0);
        for (int k = 2; k <= 8; k++) beat(8'd255, 8'd255, 1'b1, ACC, 1'b0, 1, 511 * k, 511 * k, 1'b0);
        beat(8'd255, 8'd255, 1'b1, ACC, 1'b1, 1, 503, 4095, 1'b1);
        beat(8'd1, 8'd0, 1'b0, ACC, 1'b0, 1, 1, 1, 1'b0);
        drain();

        rdy_mode = 1;
        @(negedge clk);
        base = n_acc;
        fork
            begin
                for (int k = 1; k <= 4; k++) beat(8'(k), 8'd0, 1'b0, ADD, 1'b0, 1, k, k, 1'b0);
                in_valid = 1'b0;
            end
        join_none
        repeat (5) @(negedge clk);
        #4;
        chk("bp accepted", n_acc - base, 2);
        chk("bp in_ready", ir0, 0);
        chk("bp out_valid", ov0, 1);
        chk("bp sm held", sm0, 1);
        rdy_mode = 0;
        wait fork;
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            beat(8'($urandom), 8'($urandom), 1'($urandom), ACC, $urandom_range(15) == 0, 0, 0, 0, 1'b0);
            if ($urandom_range(3) == 0) idle(1);
        end
        rdy_mode = 0;
        drain();

        rdy_mode = 1;
        @(negedge clk);
        beat(8'd150, 8'd150, 1'b0, LOAD, 1'b0, 1, 300, 300, 1'b0);
        beat(8'd1, 8'd0, 1'b0, ADD, 1'b0, 1, 1, 1, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        macc = '{0, 0};
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        chk("midrst out_valid", ov0, 0);
        chk("midrst in_ready", ir0, 1);
        chk("midrst out_valid sat", ov1, 0);
        rdy_mode = 0;
        @(negedge clk);
        beat(8'd5, 8'd0, 1'b0, ACC, 1'b0, 1, 5, 5, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
